// File: rtl/shift_serializer_pkg.sv
// Shared types and constants for the serial transmitter.
package shift_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/bit_counter.sv
// Bit position counter: clears on load, advances on each consumed bit.
module bit_counter
  import shift_serializer_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          at_last
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign at_last = (count == CW'(N - 1));

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial transmitter with valid/ready load and selectable bit order.
module shift_serializer
  import shift_serializer_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] data_in,
  input  logic         direction,
  input  logic         enable,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         frame_start,
  output logic         frame_end,
  output logic         busy,
  output logic         done
);

  ser_state_t    state, state_next;
  logic [N-1:0]  sr;
  logic          dir_q;
  logic          done_q;
  logic [CW-1:0] cnt;
  logic          at_last;
  logic          load;
  logic          step;

  assign load = (state == IDLE) && load_valid;
  assign step = (state == SHIFT) && enable;

  bit_counter #(
    .N (N),
    .CW(CW)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (load),
    .enable (step),
    .count  (cnt),
    .at_last(at_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      sr     <= '0;
      dir_q  <= DIR_LSB_FIRST;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= (state_next == DONE);
      if (load) begin
        sr    <= data_in;
        dir_q <= direction;
      end else if (step) begin
        // Shift toward whichever end feeds serial_out, zero-filling behind.
        sr <= (dir_q == DIR_MSB_FIRST) ? {sr[N-2:0], 1'b0} : {1'b0, sr[N-1:1]};
      end
    end
  end

  always_comb begin
    state_next   = state;
    load_ready   = 1'b0;
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    frame_start  = 1'b0;
    frame_end    = 1'b0;
    busy         = 1'b1;
    unique case (state)
      IDLE: begin
        load_ready = 1'b1;
        busy       = 1'b0;
        if (load_valid) state_next = SHIFT;
      end
      SHIFT: begin
        serial_valid = 1'b1;
        serial_out   = (dir_q == DIR_MSB_FIRST) ? sr[N-1] : sr[0];
        frame_start  = (cnt == '0);
        frame_end    = at_last;
        if (enable && at_last) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Scoreboard bench for shift_serializer: N=16 directed/loopback frames plus an N=2 boundary instance.
module tb_shift_serializer;
  import shift_serializer_pkg::*;

  localparam int N = 16;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         load_valid = 1'b0, load_ready, direction = 1'b0, enable = 1'b0;
  logic [N-1:0] data_in = '0;
  logic         serial_out, serial_valid, frame_start, frame_end, busy, done;

  logic         load_valid2 = 1'b0, load_ready2, direction2 = 1'b0, enable2 = 1'b0;
  logic [1:0]   data_in2 = '0;
  logic         serial_out2, serial_valid2, frame_start2, frame_end2, busy2, done2;

  shift_serializer #(.N(N)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .direction(direction), .enable(enable),
    .serial_out(serial_out), .serial_valid(serial_valid), .frame_start(frame_start),
    .frame_end(frame_end), .busy(busy), .done(done)
  );

  shift_serializer #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .load_valid(load_valid2), .load_ready(load_ready2),
    .data_in(data_in2), .direction(direction2), .enable(enable2),
    .serial_out(serial_out2), .serial_valid(serial_valid2), .frame_start(frame_start2),
    .frame_end(frame_end2), .busy(busy2), .done(done2)
  );

  exp_t q[$];
  exp_t q2[$];
  int n_pass = 0;
  int n_total = 0;
  logic done_exp = 1'b0;
  logic [N-1:0] rx = '0;
  logic rx_dir = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Bit monitor for the N=16 instance: holds a bit until enable consumes it.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      done_exp <= 1'b0;
    end else begin
      chk("done", 32'(done), 32'(done_exp));
      done_exp <= 1'b0;
      if (serial_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_bit", 32'(serial_valid), 32'(0));
        end else begin
          chk("serial_out", 32'(serial_out), 32'(q[0].b));
          chk("frame_start", 32'(frame_start), 32'(q[0].first));
          chk("frame_end", 32'(frame_end), 32'(q[0].last));
          chk("ready_busy_in_shift", 32'({load_ready, busy}), 32'(2'b01));
          if (enable) begin
            done_exp <= q[0].last;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      q2.delete();
    end else if (serial_valid2) begin
      if (q2.size() == 0) begin
        chk("n2_unexpected_bit", 32'(serial_valid2), 32'(0));
      end else begin
        chk("n2_serial_out", 32'(serial_out2), 32'(q2[0].b));
        chk("n2_frame_start", 32'(frame_start2), 32'(q2[0].first));
        chk("n2_frame_end", 32'(frame_end2), 32'(q2[0].last));
        if (enable2) void'(q2.pop_front());
      end
    end
  end

  // Receiver shift register model fed by serial_out.
  always @(posedge clk) begin
    if (serial_valid && enable)
      rx <= rx_dir ? {rx[N-2:0], serial_out} : {serial_out, rx[N-1:1]};
  end

  task automatic send(input logic [N-1:0] w, input logic d, input int period,
                      input int abort_bits, input int glitch_at,
                      output int done_cyc, output int en_cnt);
    exp_t e;
    done_cyc = -1;
    en_cnt = 0;
    load_valid = 1'b1;
    data_in = w;
    direction = d;
    enable = 1'b1;
    rx_dir = d;
    for (int i = 0; i < N; i++) begin
      e.b = d ? w[N-1-i] : w[i];
      e.first = (i == 0);
      e.last = (i == N - 1);
      q.push_back(e);
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    data_in = N'($urandom);
    direction = ~d;
    for (int c = 1; c < 200; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      if (abort_bits > 0 && en_cnt == abort_bits) begin
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        enable = 1'b0;
        return;
      end
      enable = ((c - 1) % period == 0);
      load_valid = (glitch_at > 0 && c >= glitch_at && c < glitch_at + 4);
      if (load_valid) data_in = '1;
      if (serial_valid && enable) en_cnt++;
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    enable = 1'b0;
    if (done_cyc < 0) begin
      chk("done_timeout", 32'(0), 32'(1));
    end else begin
      @(posedge clk); #1;
      chk("ready_after_done", 32'({load_ready, busy}), 32'(2'b10));
      chk("loopback_word", 32'(rx), 32'(w));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, ec;
    exp_t e;
    logic [N-1:0] w;
    logic d;

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("reset_outputs",
        32'({load_ready, busy, done, serial_out, serial_valid, frame_start, frame_end}),
        32'(7'b1000000));
    chk("n2_reset_ready_busy", 32'({load_ready2, busy2, done2}), 32'(3'b100));

    send(16'hA5C3, 1'b1, 1, 0, 0, dc, ec);
    chk("msb_done_cycle", 32'(dc), 32'(17));
    chk("msb_enabled_bits", 32'(ec), 32'(16));

    send(16'h0001, 1'b0, 3, 0, 0, dc, ec);
    chk("lsb_gated_done_cycle", 32'(dc), 32'(47));
    chk("lsb_gated_enabled_bits", 32'(ec), 32'(16));

    send(16'h1234, 1'b1, 1, 0, 5, dc, ec);
    chk("busy_ignore_done_cycle", 32'(dc), 32'(17));

    send(16'hBEEF, 1'b1, 1, 5, 0, dc, ec);
    chk("reset_midframe_outputs",
        32'({load_ready, busy, done, serial_out, serial_valid, frame_start, frame_end}),
        32'(7'b1000000));
    send(16'h8001, 1'b1, 1, 0, 0, dc, ec);
    chk("after_reset_done_cycle", 32'(dc), 32'(17));

    for (int i = 0; i < 100; i++) begin
      w = N'($urandom);
      d = 1'($urandom);
      send(w, d, (i % 2) + 1, 0, 0, dc, ec);
    end

    // Boundary: two-bit word, MSB first, enable held high.
    load_valid2 = 1'b1;
    data_in2 = 2'b10;
    direction2 = 1'b1;
    enable2 = 1'b1;
    e = '{b: 1'b1, first: 1'b1, last: 1'b0};
    q2.push_back(e);
    e = '{b: 1'b0, first: 1'b0, last: 1'b1};
    q2.push_back(e);
    @(posedge clk); #1;
    load_valid2 = 1'b0;
    data_in2 = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      chk("n2_done", 32'(done2), 32'(c == 3));
      chk("n2_load_ready", 32'(load_ready2), 32'(c == 4));
      @(posedge clk); #1;
    end
    enable2 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("queues_drained", 32'(q.size() + q2.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_serializer.md
# shift_serializer

Parallel-to-serial transmitter: accepts an N-bit word through a valid/ready load handshake and emits it one bit per enabled clock, MSB-first or LSB-first. It is the sending end of the serial link whose receiving end is the team's serial-in shift register. `direction`=1 pairs with a receiver shifting left; `direction`=0 pairs with a receiver shifting right. A receiver fed this block's `serial_out`, strobed with the same `enable`, holds the original word after N bits.

## Interface
- `N`, 16, word width in bits; N >= 2.
- `CW`, $clog2(N+1), bit-counter width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `load_valid`  in  1  `data_in` and `direction` are valid.
- `load_ready`  out  1  block can accept a word (IDLE only).
- `data_in`  in  N  word to transmit.
- `direction`  in  1  bit order, sampled at load: 1 = MSB first, 0 = LSB first.
- `enable`  in  1  bit strobe; one bit is consumed per cycle with `enable`=1 in SHIFT.
- `serial_out`  out  1  current bit.
- `serial_valid`  out  1  `serial_out` carries a bit (state SHIFT).
- `frame_start`  out  1  current bit is the first of the word.
- `frame_end`  out  1  current bit is the last of the word.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the last bit is consumed.

## Operation
- States: IDLE, SHIFT, DONE. Encoding comes from the shared package.
- IDLE:
  - `load_ready`=1.
  - On `load_valid`=1: latch `data_in` into shift register `sr`, latch `direction` into `dir_q`, clear bit counter `cnt` to 0, go to SHIFT.
- SHIFT:
  - `serial_out` = `dir_q` ? `sr[N-1]` : `sr[0]`.
  - On `enable`=1: `cnt`++, and `sr` shifts toward the output end with zero fill: left when `dir_q`=1, right when `dir_q`=0.
  - When `enable`=1 and `cnt`==N-1: go to DONE.
  - With `enable`=0: `sr` and `cnt` hold, and the same bit stays on `serial_out`.
- DONE: `done`=1 for this one cycle, then IDLE. `load_ready`=0.
- `frame_start` = SHIFT && `cnt`==0. `frame_end` = SHIFT && `cnt`==N-1. Both are combinational from state and `cnt`.
- `load_valid` outside IDLE is ignored; the word is not captured and no error is flagged.
- Changes to `data_in` or `direction` after the load handshake have no effect on the frame in flight.
- `enable` outside SHIFT is ignored.
- Outputs outside SHIFT: `serial_out`=0, `serial_valid`=0.

## Timing
- Reset (`reset`=0 at a rising edge), from any state including mid-frame:
  - state returns to IDLE; `sr`, `cnt`, `dir_q` clear to 0.
  - Next cycle: `load_ready`=1; `busy`, `done`, `serial_out`, `serial_valid`, `frame_start`, `frame_end` all 0.
  - The partial frame is discarded.
- Load handshake at edge T. The first bit is on `serial_out` with `serial_valid`=1 in cycle T+1, which is zero-wait.
- Frame length: exactly N cycles with `enable`=1 while in SHIFT.
  - With `enable` tied high: SHIFT spans cycles T+1..T+N, `done` is high in T+N+1, `load_ready` returns in T+N+2.
- Throughput with `enable` tied high: one word per N+2 cycles.
- No back-to-back bypass: DONE is always visited.
- Registered: state, `sr`, `cnt`, `dir_q`, `done`.
- Combinational: `serial_out`, `serial_valid`, `frame_start`, `frame_end`, `load_ready`, `busy`.

## Structure
- Package `shift_serializer_pkg`:
  - state enum `ser_state_t` {IDLE, SHIFT, DONE};
  - direction constants `DIR_LSB_FIRST`=0, `DIR_MSB_FIRST`=1.
- One sub-module: `bit_counter`.
  - Parameters CW and N.
  - Inputs: clear, enable, reset.
  - Outputs: `count`, `at_last` (count==N-1).
  - Instantiated once.
- FSM and shift register live in the top module.

## Test plan
- MSB-first, `enable` high:
  - Stimulus: N=16, `direction`=1, `data_in`=16'hA5C3.
  - Required: `serial_out` sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - `frame_start` on bit 0 only; `frame_end` on bit 15 only; `done` in cycle T+17.
- LSB-first, gated enable:
  - Stimulus: `direction`=0, `data_in`=16'h0001, `enable` high every third cycle.
  - Required: first bit 1, remaining 15 bits 0; each bit held stable across disabled cycles.
  - 16 enabled cycles total before `done`.
- Loopback:
  - Stimulus: `serial_out` drives the receiver shift register with the same `direction` and `enable`; random words over 100 frames.
  - Required: receiver word equals the sent word after each `done`.
- Busy ignore:
  - Stimulus: `load_valid`=1 with `data_in`=16'hFFFF asserted mid-frame of 16'h1234.
  - Required: transmitted stream is still 16'h1234; `load_ready`=0 throughout.
- Reset mid-frame:
  - Stimulus: `reset`=0 after 5 bits of 16'hBEEF.
  - Required: next cycle all outputs 0 and `load_ready`=1.
  - A following load of 16'h8001 transmits cleanly from bit 0.
- Boundary:
  - Stimulus: N=2, `data_in`=2'b10, `direction`=1, `enable` high.
  - Required: bits 1,0; `frame_start` and `frame_end` in consecutive cycles; `done` at T+3; `load_ready` at T+4.
